// File: rtl/multdiv_pkg.sv
// Shared constants for the sequential multiplier/divider pair.
package multdiv_pkg;
  localparam int unsigned N_DEF  = 3;
  localparam int unsigned W2_DEF = 2 * N_DEF;

  // State encodings shared with the multiplier rewrite
  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_RUN    = 2'b01;
  localparam logic [1:0] S_FINISH = 2'b11;
endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus for the sequential divider.
interface seq_divider_if
  import multdiv_pkg::*;
#(
  parameter int unsigned N = N_DEF
) ();
  logic             start;
  logic [2*N-1:0]   dividend;
  logic [N-1:0]     divisor;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [2*N-1:0]   quotient;
  logic [N-1:0]     remainder;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_by_zero, quotient, remainder
  );
endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division iteration.
module div_step
  import multdiv_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic [N:0]   i_r,
  input  logic         i_q_msb,
  input  logic [N-1:0] i_d,
  output logic [N:0]   o_r_next_c,
  output logic         o_q_bit_c
);
  logic [N:0] w_t;
  logic       w_ge;

  // Shift in the next dividend bit and subtract the divisor when it fits.
  // A set i_r[N] would mean the partial remainder already exceeds D, so it
  // forces the subtract; with R < D maintained it is always 0.
  always_comb begin
    w_t        = {i_r[N-1:0], i_q_msb};
    w_ge       = i_r[N] | (w_t >= {1'b0, i_d});
    o_r_next_c = w_ge ? (w_t - {1'b0, i_d}) : w_t;
    o_q_bit_c  = w_ge;
  end
endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one
// quotient bit per clock, start/done handshake.
module seq_divider
  import multdiv_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);
  localparam int unsigned W2 = 2 * N;
  localparam int unsigned CW = $clog2(W2) + 1;

  logic [1:0]    r_state, w_nx_state;
  logic [W2-1:0] r_q, w_nx_q;
  logic [N:0]    r_r, w_nx_r;
  logic [N-1:0]  r_d, w_nx_d;
  logic [CW-1:0] r_cnt, w_nx_cnt;
  logic          r_busy, w_nx_busy;
  logic          r_done, w_nx_done;
  logic          r_dbz, w_nx_dbz;
  logic [W2-1:0] r_quot, w_nx_quot;
  logic [N-1:0]  r_rem, w_nx_rem;

  logic [N:0]    w_r_step;
  logic          w_q_bit;
  logic [W2-1:0] w_q_shift;

  div_step #(.N(N)) u_step (
    .i_r        (r_r),
    .i_q_msb    (r_q[W2-1]),
    .i_d        (r_d),
    .o_r_next_c (w_r_step),
    .o_q_bit_c  (w_q_bit)
  );

  assign w_q_shift = {r_q[W2-2:0], w_q_bit};

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_r     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_nx_state;
      r_q     <= w_nx_q;
      r_r     <= w_nx_r;
      r_d     <= w_nx_d;
      r_cnt   <= w_nx_cnt;
      r_busy  <= w_nx_busy;
      r_done  <= w_nx_done;
      r_dbz   <= w_nx_dbz;
      r_quot  <= w_nx_quot;
      r_rem   <= w_nx_rem;
    end
  end

  // Next-state and next-datapath logic; every register holds by default
  always_comb begin
    w_nx_state = r_state;
    w_nx_q     = r_q;
    w_nx_r     = r_r;
    w_nx_d     = r_d;
    w_nx_cnt   = r_cnt;
    w_nx_busy  = r_busy;
    w_nx_done  = r_done;
    w_nx_dbz   = r_dbz;
    w_nx_quot  = r_quot;
    w_nx_rem   = r_rem;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_nx_d     = bus.divisor;
          w_nx_q     = bus.dividend;
          w_nx_r     = '0;
          w_nx_cnt   = '0;
          w_nx_done  = 1'b0;
          w_nx_dbz   = 1'b0;
          w_nx_busy  = 1'b1;
          w_nx_state = (bus.divisor == '0) ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        w_nx_q   = w_q_shift;
        w_nx_r   = w_r_step;
        w_nx_cnt = r_cnt + CW'(1);
        if (r_cnt == CW'(W2 - 1)) begin
          w_nx_quot  = w_q_shift;
          w_nx_rem   = w_r_step[N-1:0];
          w_nx_done  = 1'b1;
          w_nx_busy  = 1'b0;
          w_nx_state = S_IDLE;
        end
      end
      S_FINISH: begin
        w_nx_quot  = '1;
        w_nx_rem   = '0;
        w_nx_dbz   = 1'b1;
        w_nx_done  = 1'b1;
        w_nx_busy  = 1'b0;
        w_nx_state = S_IDLE;
      end
      default: w_nx_state = S_IDLE;
    endcase
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver pushes reference results,
// a negedge monitor pops and compares on every rising done.
module tb_seq_divider;
  import multdiv_pkg::*;

  localparam int unsigned N  = N_DEF;
  localparam int unsigned W2 = W2_DEF;

  typedef struct packed {
    logic [W2-1:0] quot;
    logic [N-1:0]  rem;
    logic          dbz;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  seq_divider_if #(.N(N)) bus ();

  seq_divider #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer division, all-ones quotient on /0
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.quot = '1;
      e.rem  = '0;
      e.dbz  = 1'b1;
    end else begin
      e.quot = W2'(a / b);
      e.rem  = N'(a % b);
      e.dbz  = 1'b0;
    end
    return e;
  endfunction

  // One operation; optionally re-pulses start with new operands at edge 3
  task automatic run_op(input int a, input int b, input bit ign);
    int busy_cyc;
    int lat;
    bit got;
    int exp_lat;
    exp_lat = (b == 0) ? 1 : int'(W2);
    bus.dividend = W2'(a);
    bus.divisor  = N'(b);
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    exp_q.push_back(model(a, b));
    chk("accept_busy", 64'(bus.busy), 64'd1);
    chk("accept_done_low", 64'(bus.done), 64'd0);
    busy_cyc = 1;
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      if (ign && k == 3) begin
        bus.start    = 1'b1;
        bus.dividend = W2'(10);
        bus.divisor  = N'(3);
      end
      tick();
      bus.start = 1'b0;
      if (bus.done) begin
        got = 1'b1;
        lat = k;
      end else if (bus.busy) begin
        busy_cyc++;
      end
    end
    chk("done_seen", 64'(got), 64'd1);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("busy_cycles", 64'(busy_cyc), 64'(exp_lat));
    chk("busy_low_at_done", 64'(bus.busy), 64'd0);
  endtask

  // Monitor: compare every completion against the oldest expectation
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done && !prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected no pending operation");
        end else begin
          e = exp_q.pop_front();
          chk("quotient", 64'(bus.quotient), 64'(e.quot));
          chk("remainder", 64'(bus.remainder), 64'(e.rem));
          chk("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
        end
      end
      prev = bus.done;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dz;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    chk("rst_quot", 64'(bus.quotient), 64'd0);
    chk("rst_rem", 64'(bus.remainder), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed cases
    run_op(45, 6, 1'b0);
    run_op(63, 1, 1'b0);
    run_op(5, 7, 1'b0);
    run_op(20, 0, 1'b0);
    run_op(20, 4, 1'b0);
    run_op(45, 6, 1'b1);
    chk("done_held_before_restart", 64'(bus.done), 64'd1);
    run_op(0, 7, 1'b0);

    // Reset mid-operation aborts without a done
    bus.dividend = W2'(45);
    bus.divisor  = N'(6);
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_quot", 64'(bus.quotient), 64'd0);
    chk("abort_rem", 64'(bus.remainder), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dz = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.done || bus.busy) dz++;
    end
    chk("abort_quiet", 64'(dz), 64'd0);
    run_op(12, 5, 1'b0);

    // Round trip: (A*B)/B == A remainder 0
    for (int a = 0; a < 8; a++)
      for (int b = 1; b < 8; b++)
        run_op(a * b, b, 1'b0);

    // Exhaustive dividend x nonzero divisor
    for (int a = 0; a < 64; a++)
      for (int b = 1; b < 8; b++)
        run_op(a, b, 1'b0);

    // Random mix including divide by zero
    for (int i = 0; i < 40; i++)
      run_op(int'($urandom_range(0, 63)), int'($urandom_range(0, 7)), 1'b0);

    repeat (3) tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
